// File: rtl/rv64g_pkg.sv
// Shared RV64G core constants.
// Register file geometry used across pipeline stages.
package rv64g_pkg;

   localparam int NUM_REGS = 64;

endpackage

// File: rtl/reg_lock_tracker.sv
// Architectural register lock state for issue, closing the loop
// around reg_gnt_ckr; jumps drain all in-flight work before resuming.
module reg_lock_tracker
   import rv64g_pkg::*;
#(
   parameter int  NR           = NUM_REGS,
   parameter int  MAX_INFLIGHT = 15,
   localparam int RW           = $clog2(NR),
   localparam int CW           = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic          clk_i,
   input  logic          arst_ni,
   input  logic          issue_valid_i,
   input  logic [NR-1:0] issue_locks_i,
   input  logic          issue_jump_i,
   input  logic          wb_valid_i,
   input  logic [RW-1:0] wb_rd_i,
   output logic [NR-1:0] locks_o,
   output logic [CW-1:0] inflight_o,
   output logic          full_o,
   output logic          draining_o
);

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_e;

   state_e        state_q, state_d;
   logic [NR-1:0] locks_q, locks_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          iss;
   logic          wb;
   logic [NR-1:0] wb_mask;

   // Status decoded from flops only, so the checker loop stays acyclic.
   assign full_o     = (cnt_q == CW'(MAX_INFLIGHT));
   assign draining_o = (state_q == DRAIN);
   assign inflight_o = cnt_q;
   assign locks_o    = draining_o ? '1 : locks_q;

   always_comb begin
      iss     = issue_valid_i & ~full_o & (state_q == RUN);
      wb      = wb_valid_i & (cnt_q != '0);
      wb_mask = wb ? (NR'(1) << wb_rd_i) : '0;

      state_d = state_q;
      cnt_d   = cnt_q;

      // Set is applied after clear so a re-lock of rd survives its own wb.
      locks_d = locks_q & ~wb_mask;
      if (iss) begin
         locks_d = locks_d | issue_locks_i;
      end
      locks_d[0] = 1'b0;

      if (iss & ~wb) begin
         cnt_d = cnt_q + CW'(1);
      end else if (wb & ~iss) begin
         cnt_d = cnt_q - CW'(1);
      end

      unique case (state_q)
         RUN: begin
            if (iss & issue_jump_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = RUN;
               locks_d = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= RUN;
         locks_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         locks_q <= locks_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_reg_lock_tracker.sv
// Scoreboard bench for reg_lock_tracker: directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_reg_lock_tracker;

   localparam int NR   = 64;
   localparam int MAXI = 15;

   logic          clk_i = 1'b0;
   logic          arst_ni = 1'b0;
   logic          issue_valid_i = 1'b0;
   logic [NR-1:0] issue_locks_i = '0;
   logic          issue_jump_i = 1'b0;
   logic          wb_valid_i = 1'b0;
   logic [5:0]    wb_rd_i = '0;
   logic [NR-1:0] locks_o;
   logic [3:0]    inflight_o;
   logic          full_o;
   logic          draining_o;

   reg_lock_tracker #(
      .NR          (NR),
      .MAX_INFLIGHT(MAXI)
   ) dut (
      .clk_i        (clk_i),
      .arst_ni      (arst_ni),
      .issue_valid_i(issue_valid_i),
      .issue_locks_i(issue_locks_i),
      .issue_jump_i (issue_jump_i),
      .wb_valid_i   (wb_valid_i),
      .wb_rd_i      (wb_rd_i),
      .locks_o      (locks_o),
      .inflight_o   (inflight_o),
      .full_o       (full_o),
      .draining_o   (draining_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [NR-1:0] locks;
      int            cnt;
      bit            full;
      bit            drn;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   logic [NR-1:0] m_locks = '0;
   int            m_cnt = 0;
   bit            m_drain = 1'b0;

   task automatic chk(input string name, input logic [NR-1:0] act,
                      input logic [NR-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input bit iv, input logic [NR-1:0] lk,
                             input bit jmp, input bit wv,
                             input logic [5:0] rd);
      bit iss;
      bit wb;
      iss = iv && (m_cnt < MAXI) && !m_drain;
      wb  = wv && (m_cnt > 0);
      if (m_drain && m_cnt == 0) begin
         m_drain = 1'b0;
         m_locks = '0;
      end else begin
         if (wb) m_locks[rd] = 1'b0;
         if (iss) m_locks = m_locks | lk;
         m_locks[0] = 1'b0;
         m_cnt = m_cnt + (iss ? 1 : 0) - (wb ? 1 : 0);
         if (iss && jmp) m_drain = 1'b1;
      end
   endtask

   task automatic apply(input bit iv, input logic [NR-1:0] lk,
                        input bit jmp, input bit wv, input logic [5:0] rd);
      exp_t e;
      issue_valid_i = iv;
      issue_locks_i = lk;
      issue_jump_i  = jmp;
      wb_valid_i    = wv;
      wb_rd_i       = rd;
      model_step(iv, lk, jmp, wv, rd);
      e.locks = m_drain ? '1 : m_locks;
      e.cnt   = m_cnt;
      e.full  = (m_cnt == MAXI);
      e.drn   = m_drain;
      sb.push_back(e);
   endtask

   task automatic drive(input bit iv, input logic [NR-1:0] lk,
                        input bit jmp, input bit wv, input logic [5:0] rd);
      @(negedge clk_i);
      apply(iv, lk, jmp, wv, rd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, '0, 0, 0, 6'd0);
   endtask

   task automatic issue(input int rd, input bit jmp);
      logic [NR-1:0] lk;
      lk = m_locks | (NR'(1) << rd);
      drive(1, lk, jmp, 0, 6'd0);
   endtask

   task automatic retire(input int rd);
      drive(0, '0, 0, 1, 6'(rd));
   endtask

   // Asynchronous reset between clock edges, checked before any edge.
   task automatic async_reset();
      @(negedge clk_i);
      issue_valid_i = 0;
      wb_valid_i    = 0;
      #1 arst_ni = 1'b0;
      #1;
      chk("rst_locks", locks_o, '0);
      chk("rst_cnt", NR'(inflight_o), '0);
      chk("rst_full", NR'(full_o), '0);
      chk("rst_drain", NR'(draining_o), '0);
      #1 arst_ni = 1'b1;
      m_locks = '0;
      m_cnt   = 0;
      m_drain = 1'b0;
      apply(0, '0, 0, 0, 6'd0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk_i);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("locks", locks_o, e.locks);
            chk("inflight", NR'(inflight_o), NR'(e.cnt));
            chk("full", NR'(full_o), NR'(e.full));
            chk("draining", NR'(draining_o), NR'(e.drn));
         end
      end
   end

   initial begin : stim
      repeat (3) @(negedge clk_i);
      arst_ni = 1'b1;
      #1;
      chk("init_locks", locks_o, '0);
      chk("init_cnt", NR'(inflight_o), '0);
      chk("init_full", NR'(full_o), '0);
      chk("init_drain", NR'(draining_o), '0);
      idle(5);

      issue(5, 0);
      idle(2);
      retire(5);
      idle(2);

      issue(7, 0);
      issue(3, 0);
      drive(1, m_locks | (NR'(1) << 7), 0, 1, 6'd7);
      retire(7);
      retire(3);
      idle(1);

      for (int i = 0; i < 16; i++) issue(1 + i, 0);
      retire(1);
      idle(1);
      for (int i = 0; i < 14; i++) retire(2 + i);
      idle(1);

      issue(4, 0);
      issue(6, 0);
      issue(9, 0);
      issue(1, 1);
      issue(10, 0);
      retire(4);
      retire(6);
      retire(9);
      retire(1);
      idle(3);

      issue(12, 0);
      issue(0, 1);
      idle(1);
      async_reset();
      idle(2);

      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            async_reset();
         end else begin
            drive(1'($urandom_range(0, 1)),
                  m_locks | (NR'(1) << $urandom_range(0, NR - 1)),
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 2) != 0,
                  6'($urandom_range(0, NR - 1)));
         end
      end
      idle(2);

      repeat (3) @(posedge clk_i);
      #2;
      chk("sb_empty", NR'(sb.size()), '0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_lock_tracker.md
# reg_lock_tracker

Holds the architectural register lock state for the issue stage and closes the loop around `reg_gnt_ckr`. It drives `locks_o` into the checker's `locks_i`, and takes the checker's `locks_o` back when an instruction is granted. Locks are released when writeback retires a destination register. A jump puts the tracker into a drain state that holds every register locked until all in-flight instructions have retired.

## Interface
Parameters:
- `NR`, default `rv64g_pkg::NUM_REGS` (64): number of tracked registers; index 0 is hard-wired zero.
- `MAX_INFLIGHT`, default 15: maximum number of outstanding issued-but-not-written-back instructions.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i`  in  1  system clock, all state updates on its rising edge.
- `arst_ni`  in  1  asynchronous active-low reset.
- `issue_valid_i`  in  1  one instruction granted this cycle.
- `issue_locks_i`  in  NR  `locks_o` of `reg_gnt_ckr` for the granted instruction (current locks | rd).
- `issue_jump_i`  in  1  granted instruction is a jump/branch redirect; qualified by `issue_valid_i`.
- `wb_valid_i`  in  1  writeback of one instruction completes this cycle.
- `wb_rd_i`  in  $clog2(NR)  destination index being written back.
- `locks_o`  out  NR  lock vector to `reg_gnt_ckr.locks_i`.
- `inflight_o`  out  $clog2(MAX_INFLIGHT+1)  outstanding instruction count.
- `full_o`  out  1  `inflight_o == MAX_INFLIGHT`; upstream must not issue.
- `draining_o`  out  1  FSM in DRAIN.

## Operation
- State: `locks_q[NR-1:0]`, counter `cnt_q`, FSM {RUN, DRAIN}.
- Effective issue: `iss = issue_valid_i & ~full_o & (state == RUN)`. Issue in DRAIN or when full is dropped; counter and locks are unchanged.
- Effective writeback: `wb = wb_valid_i & (cnt_q != 0)`. Writeback at zero is dropped.
- Lock update, in order:
  - clear: `locks_q & ~(wb ? 1<<wb_rd_i : 0)`;
  - then set: `| (iss ? issue_locks_i : 0)`;
  - then force bit 0 to 0.
  - Set wins over clear on the same index.
- Counter: +1 on `iss` only, -1 on `wb` only, unchanged when both or neither. It never wraps.
- FSM:
  - RUN -> DRAIN on `iss & issue_jump_i`. The jump itself is counted in flight.
  - DRAIN -> RUN when `cnt_q == 0` is observed at a clock edge. On that same edge `locks_q` is cleared to all zero.
  - Writebacks continue to decrement in DRAIN.
- `locks_o`:
  - in RUN: `locks_q`;
  - in DRAIN: all ones, bit 0 included, matching the checker's jump rule so `arb_req_o` stays low.
- `full_o` and `draining_o` are decoded from registered state (no input-to-output combinational path). This keeps the `reg_gnt_ckr` loop free of combinational cycles.

## Timing
- Reset (asynchronous assert, synchronous-release usage):
  - `locks_o = 0`, `inflight_o = 0`, `full_o = 0`, `draining_o = 0`, state RUN.
  - Reset mid-DRAIN aborts the drain immediately.
- Issue at edge N: locks and count visible from cycle N+1, so the checker sees them on the very next grant.
- Writeback at edge N: lock bit clear and decrement visible at N+1.
- Jump issued at edge N: `draining_o` and all-ones `locks_o` from N+1.
  - Last writeback (count 1 -> 0) at edge M.
  - `cnt_q == 0` is seen at edge M+1, which exits to RUN.
  - `locks_o = 0` and `draining_o = 0` from cycle M+1 onward (after edge M+1).
- Jump with `cnt` already 0 after the jump's own writeback in the same cycle as issue: count stays at 1, the normal drain applies.
- Full: `full_o` rises the cycle after the count reaches MAX. A simultaneous issue and writeback at full is an issue dropped, writeback taken; count becomes MAX-1.

## Test plan
- Reset, then idle 5 cycles -> `locks_o = 0`, `inflight_o = 0`, `full_o = draining_o = 0`.
- Issue with `issue_locks_i = 0x20` (rd = 5), then `wb_rd_i = 5` 3 cycles later:
  - `locks_o[5]` = 1 from cycle +1 through the writeback edge, 0 after;
  - `inflight_o` 1 -> 0.
- Same cycle: `wb_rd_i = 7` plus an issue locking reg 7 (count = 2 beforehand) -> `locks_o[7]` stays 1, `inflight_o` stays 2.
- Issue 15 non-jump instructions back to back:
  - `full_o = 1`, a 16th issue is ignored, `inflight_o = 15`;
  - one writeback -> `full_o = 0` next cycle.
- Jump issued with 3 others in flight:
  - `locks_o = '1` and `draining_o = 1` until 4 writebacks land;
  - an issue attempted during DRAIN is ignored;
  - RUN is resumed with `locks_o = 0`.
- Assert `arst_ni` low mid-DRAIN with `inflight_o = 2` -> all outputs 0 immediately, with no clock edge required.
